// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg
// Shared definitions for the multicycle MIPS control unit: FSM state
// encoding, opcode and funct field values, and ALU operation codes.
// No ports; imported by mips_multicycle_ctrl and mips_mc_aludec.
package mips_mc_pkg;

  // Step encoding is visible on the debug state port, so values are fixed.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Code 2'b11 is unused; the decoder treats it as add.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_aludec.sv
// mips_mc_aludec
// ALU decoder: maps the FSM's aluop and the instruction funct field to the
// ALU control code, and flags whether funct is a supported R-type function.
// Ports:
//   aluop       in  2  00 add, 01 sub, 10 use funct
//   funct       in  6  IR[5:0]
//   alucontrol  out 3  ALU operation select
//   funct_valid out 1  funct is one of add/sub/and/or/slt
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  logic [2:0] funct_map_s;

  // Decode funct; unsupported codes fall back to add and are flagged invalid.
  always_comb begin
    funct_map_s = ALU_ADD;
    funct_valid = 1'b0;
    case (funct)
      FN_ADD:  begin funct_map_s = ALU_ADD; funct_valid = 1'b1; end
      FN_SUB:  begin funct_map_s = ALU_SUB; funct_valid = 1'b1; end
      FN_AND:  begin funct_map_s = ALU_AND; funct_valid = 1'b1; end
      FN_OR:   begin funct_map_s = ALU_OR;  funct_valid = 1'b1; end
      FN_SLT:  begin funct_map_s = ALU_SLT; funct_valid = 1'b1; end
      default: begin funct_map_s = ALU_ADD; funct_valid = 1'b0; end
    endcase
  end

  // Select the ALU operation from aluop.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_map_s;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Moore FSM sequencing a multicycle MIPS datapath (shared ALU and memory)
// through fetch/decode/execute/memory/writeback, one step per clock.
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   op, funct            IR[31:26], IR[5:0]
//   zero                 ALU zero flag (branch resolution)
//   mem_ready            memory finishes the current access this cycle
//   pcen .. alucontrol   datapath selects and write strobes
//   illegal              trap flag (unsupported op or funct)
//   state                current FSM state, debug
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_r;
  state_t next_state_s;
  aluop_t aluop_s;
  logic   pcwrite_s;
  logic   branch_s;
  logic   irwrite_s;
  logic   memwrite_s;
  logic   regwrite_s;
  logic   funct_valid_s;

  mips_mc_aludec u_aludec (
    .aluop       (aluop_s),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_valid (funct_valid_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    next_state_s = state_r;
    aluop_s      = ALUOP_ADD;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    irwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    regwrite_s   = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    illegal      = 1'b0;
    case (state_r)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_RTEX;
          OP_BEQ:       next_state_s = S_BEQEX;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JEX;
          default:      next_state_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // IR is held, so op is still lw or sw here; anything else traps.
        if (op == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (op == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_TRAP;
        end
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe is held for the whole access, including stall cycles.
        iord       = 1'b1;
        memwrite_s = 1'b1;
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop_s = ALUOP_FUNCT;
        if (funct_valid_s) begin
          next_state_s = S_RTWB;
        end else begin
          next_state_s = S_TRAP;
        end
      end
      S_RTWB: begin
        regdst       = 1'b1;
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQEX: begin
        alusrca      = 1'b1;
        aluop_s      = ALUOP_SUB;
        pcsrc        = 2'b01;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JEX: begin
        pcsrc        = 2'b10;
        pcwrite_s    = 1'b1;
        next_state_s = S_FETCH;
      end
      S_TRAP: begin
        illegal      = 1'b1;
        next_state_s = S_TRAP;
      end
      default: begin
        // Unused encodings behave as TRAP.
        illegal      = 1'b1;
        next_state_s = S_TRAP;
      end
    endcase
  end

  // Strobes are gated by reset_n so nothing fires from the moment reset falls,
  // even though FETCH's irwrite/pcwrite follow mem_ready.
  assign pcen     = reset_n & (pcwrite_s | (branch_s & zero));
  assign irwrite  = reset_n & irwrite_s;
  assign memwrite = reset_n & memwrite_s;
  assign regwrite = reset_n & regwrite_s;
  assign state    = state_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Table-driven bench for mips_multicycle_ctrl. Each record is one clock
// cycle: inputs to drive and the expected state plus output word. Expected
// words are pushed to a scoreboard queue when driven and popped when the
// outputs are sampled. Hand sequences cover the reset corner cases.
module tb_mips_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clock = ~clock;

  localparam logic [5:0] L_R    = 6'b000000;
  localparam logic [5:0] L_LW   = 6'b100011;
  localparam logic [5:0] L_SW   = 6'b101011;
  localparam logic [5:0] L_BEQ  = 6'b000100;
  localparam logic [5:0] L_ADDI = 6'b001000;
  localparam logic [5:0] L_J    = 6'b000010;
  localparam logic [5:0] L_BAD  = 6'b111111;

  // Output word: pcen irwrite memwrite iord _ regwrite regdst memtoreg alusrca
  //              _ alusrcb _ pcsrc _ alucontrol _ illegal
  localparam logic [15:0] E_F1     = 16'b1100_0000_01_00_010_0;
  localparam logic [15:0] E_F0     = 16'b0000_0000_01_00_010_0;
  localparam logic [15:0] E_DEC    = 16'b0000_0000_11_00_010_0;
  localparam logic [15:0] E_MADR   = 16'b0000_0001_10_00_010_0;
  localparam logic [15:0] E_MRD    = 16'b0001_0000_00_00_010_0;
  localparam logic [15:0] E_MWB    = 16'b0000_1010_00_00_010_0;
  localparam logic [15:0] E_MWR    = 16'b0011_0000_00_00_010_0;
  localparam logic [15:0] E_RTWB   = 16'b0000_1100_00_00_010_0;
  localparam logic [15:0] E_BEQ1   = 16'b1000_0001_00_01_110_0;
  localparam logic [15:0] E_BEQ0   = 16'b0000_0001_00_01_110_0;
  localparam logic [15:0] E_ADDIWB = 16'b0000_1000_00_00_010_0;
  localparam logic [15:0] E_JEX    = 16'b1000_0000_00_10_010_0;
  localparam logic [15:0] E_TRAP   = 16'b0000_0000_00_00_010_1;

  function automatic logic [15:0] e_rtex(input logic [2:0] alc);
    e_rtex = {12'b0000_0001_00_00, alc, 1'b0};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] outs;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic mr, input logic [3:0] st, input logic [15:0] outs);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.mr = mr; v.st = st; v.outs = outs;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [19:0] exp_w;
    logic [19:0] act_w;
    exp_w = sb_q.pop_front();
    act_w = {state, pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
             alusrca, alusrcb, pcsrc, alucontrol, illegal};
    n_vec++;
    if (act_w !== exp_w) begin
      n_err++;
      $display("FAIL %s: state+outs got %b required %b", tag, act_w, exp_w);
    end
  endtask

  // Called at a falling edge: drive, sample 1 time unit later, wait next falling edge.
  task automatic drive_check(input vec_t v, input string tag);
    op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.mr;
    sb_q.push_back({v.st, v.outs});
    #1;
    check(tag);
    @(negedge clock);
  endtask

  task automatic expect_now(input logic [3:0] st, input logic [15:0] outs, input string tag);
    sb_q.push_back({st, outs});
    #1;
    check(tag);
  endtask

  logic [5:0] rt_fn  [4];
  logic [2:0] rt_alc [4];

  initial begin
    // lw with one MEMRD stall
    add(L_LW, 6'd0, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_LW, 6'd0, 1'b0, 1'b1, 4'd1, E_DEC);
    add(L_LW, 6'd0, 1'b0, 1'b1, 4'd2, E_MADR);
    add(L_LW, 6'd0, 1'b0, 1'b0, 4'd3, E_MRD);
    add(L_LW, 6'd0, 1'b0, 1'b1, 4'd3, E_MRD);
    add(L_LW, 6'd0, 1'b0, 1'b1, 4'd4, E_MWB);
    // FETCH stall, then sw with two MEMWR stall cycles
    add(L_SW, 6'd0, 1'b0, 1'b0, 4'd0, E_F0);
    add(L_SW, 6'd0, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_SW, 6'd0, 1'b0, 1'b1, 4'd1, E_DEC);
    add(L_SW, 6'd0, 1'b0, 1'b1, 4'd2, E_MADR);
    add(L_SW, 6'd0, 1'b0, 1'b0, 4'd5, E_MWR);
    add(L_SW, 6'd0, 1'b0, 1'b0, 4'd5, E_MWR);
    add(L_SW, 6'd0, 1'b0, 1'b1, 4'd5, E_MWR);
    // beq taken, then not taken
    add(L_BEQ, 6'd0, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_BEQ, 6'd0, 1'b1, 1'b1, 4'd1, E_DEC);
    add(L_BEQ, 6'd0, 1'b1, 1'b1, 4'd8, E_BEQ1);
    add(L_BEQ, 6'd0, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_BEQ, 6'd0, 1'b0, 1'b1, 4'd1, E_DEC);
    add(L_BEQ, 6'd0, 1'b0, 1'b1, 4'd8, E_BEQ0);
    // R-type: slt, add, sub, and, or
    rt_fn[0] = 6'b101010; rt_alc[0] = 3'b111;
    rt_fn[1] = 6'b100000; rt_alc[1] = 3'b010;
    rt_fn[2] = 6'b100010; rt_alc[2] = 3'b110;
    rt_fn[3] = 6'b100100; rt_alc[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      add(L_R, rt_fn[i], 1'b0, 1'b1, 4'd0, E_F1);
      add(L_R, rt_fn[i], 1'b0, 1'b1, 4'd1, E_DEC);
      add(L_R, rt_fn[i], 1'b0, 1'b1, 4'd6, e_rtex(rt_alc[i]));
      add(L_R, rt_fn[i], 1'b0, 1'b1, 4'd7, E_RTWB);
    end
    add(L_R, 6'b100101, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_R, 6'b100101, 1'b0, 1'b1, 4'd1, E_DEC);
    add(L_R, 6'b100101, 1'b0, 1'b1, 4'd6, e_rtex(3'b001));
    add(L_R, 6'b100101, 1'b0, 1'b1, 4'd7, E_RTWB);
    // addi
    add(L_ADDI, 6'd0, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_ADDI, 6'd0, 1'b0, 1'b1, 4'd1, E_DEC);
    add(L_ADDI, 6'd0, 1'b0, 1'b1, 4'd9, E_MADR);
    add(L_ADDI, 6'd0, 1'b0, 1'b1, 4'd10, E_ADDIWB);
    // j
    add(L_J, 6'd0, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_J, 6'd0, 1'b0, 1'b1, 4'd1, E_DEC);
    add(L_J, 6'd0, 1'b0, 1'b1, 4'd11, E_JEX);
    // R-type with unsupported funct traps without writing
    add(L_R, 6'b000000, 1'b0, 1'b1, 4'd0, E_F1);
    add(L_R, 6'b000000, 1'b0, 1'b1, 4'd1, E_DEC);
    add(L_R, 6'b000000, 1'b0, 1'b1, 4'd6, e_rtex(3'b010));
    add(L_R, 6'b000000, 1'b0, 1'b1, 4'd12, E_TRAP);
    add(L_LW, 6'b100000, 1'b1, 1'b1, 4'd12, E_TRAP);

    reset_n = 1'b0; op = L_LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    expect_now(4'd0, E_F0, "reset_state");
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) drive_check(vecs[i], $sformatf("vec%0d", i));

    // Illegal opcode: DECODE then TRAP; TRAP holds until reset.
    #2 reset_n = 1'b0;
    expect_now(4'd0, E_F0, "trap_reset_clears");
    @(negedge clock);
    reset_n = 1'b1;
    begin
      vec_t v;
      v.funct = 6'd0; v.zero = 1'b0; v.mr = 1'b1; v.op = L_BAD;
      v.st = 4'd0;  v.outs = E_F1;   drive_check(v, "badop_fetch");
      v.st = 4'd1;  v.outs = E_DEC;  drive_check(v, "badop_decode");
      v.st = 4'd12; v.outs = E_TRAP; drive_check(v, "badop_trap");
      v.st = 4'd12; v.outs = E_TRAP; drive_check(v, "badop_trap_hold");
      #2 reset_n = 1'b0;
      expect_now(4'd0, E_F0, "badop_reset");
      @(negedge clock);
      reset_n = 1'b1;
      // Reset during a stalled MEMWR drops memwrite asynchronously.
      v.op = L_SW;
      v.st = 4'd0; v.outs = E_F1;   drive_check(v, "swrst_fetch");
      v.st = 4'd1; v.outs = E_DEC;  drive_check(v, "swrst_decode");
      v.st = 4'd2; v.outs = E_MADR; drive_check(v, "swrst_memadr");
      v.mr = 1'b0;
      v.st = 4'd5; v.outs = E_MWR;  drive_check(v, "swrst_memwr");
      #2 reset_n = 1'b0;
      expect_now(4'd0, E_F0, "swrst_async_drop");
      mem_ready = 1'b1;
      expect_now(4'd0, E_F0, "swrst_strobes_gated");
      @(negedge clock);
      reset_n = 1'b1;
      v.mr = 1'b1;
      v.st = 4'd0; v.outs = E_F1;  drive_check(v, "swrst_restart");
      v.st = 4'd1; v.outs = E_DEC; drive_check(v, "swrst_restart_decode");
    end

    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS control unit: a Moore FSM that sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback steps, one step per clock. It consumes the instruction register fields and the ALU zero flag, and drives every datapath select and write strobe. It stalls on a memory ready handshake and traps on unsupported opcodes or funct codes. It replaces the single-cycle main decoder in the multicycle build and sits between the instruction register and the datapath.

## Interface
- No parameters; ISA subset fixed: R-type (add, sub, and, or, slt), lw, sw, beq, addi, j.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcen  out  1  PC load: pcwrite | (branch & zero)
- irwrite  out  1  IR load
- memwrite  out  1  memory write strobe
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- regwrite  out  1  register file write
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  write data: 0 = ALUOut, 1 = Data
- alusrca  out  1  ALU A: 0 = PC, 1 = A
- alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  trap flag
- state  out  4  current state, debug

## Operation
- States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, TRAP 12. Codes 13-15 go to TRAP.
- Any output not listed for a state is 0. aluop is internal: 00 add, 01 sub, 10 funct.
- FETCH: alusrcb=01, irwrite=mem_ready, pcwrite=mem_ready.
  - Stays in FETCH while mem_ready=0.
  - Goes to DECODE when mem_ready=1.
- DECODE: alusrcb=11. Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> TRAP
- MEMADR: alusrca=1, alusrcb=10. Next MEMRD if op=lw, MEMWR if op=sw.
- MEMRD: iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1. Next FETCH.
- MEMWR: iord=1, memwrite=1 for every cycle in the state. Holds until mem_ready=1, then FETCH.
- RTEX: alusrca=1, aluop=10.
  - funct in {100000, 100010, 100100, 100101, 101010} -> RTWB.
  - Any other funct -> TRAP; no register write occurs.
- RTWB: regdst=1, regwrite=1. Next FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Next ADDIWB.
- ADDIWB: regwrite=1. Next FETCH.
- JEX: pcsrc=10, pcwrite=1. Next FETCH.
- TRAP: illegal=1, all strobes 0. Exits only by reset.
- alucontrol: aluop 00 -> 010, 01 -> 110, 10 -> funct map; unknown funct -> 010.

## Timing
- Reset (reset_n low, asynchronous): state=FETCH, illegal=0.
  - pcen, irwrite, memwrite and regwrite are forced 0 while reset_n is low.
  - Other outputs take their FETCH values: alusrcb=01, alucontrol=010, the rest 0.
- Outputs are combinational from state. Exceptions: pcen also depends on zero; irwrite and pcwrite in FETCH also depend on mem_ready.
- Cycles per instruction with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2 (then in TRAP).
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset mid-instruction aborts it. No strobe fires after reset_n falls. The first cycle after release is FETCH.
- op and funct are sampled every cycle. IR is stable after DECODE, since irwrite is only asserted in FETCH.

## Structure
- Shared package `mips_mc_pkg`:
  - state enum/localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - aluop and alucontrol codes
- One sub-module: `mips_mc_aludec` (aluop + funct -> alucontrol, plus a funct_valid output used by the RTEX transition).
- FSM state register and output decode live in the top module.

## Test plan
- Reset with op=lw, mem_ready=1; release -> state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. irwrite=1 only in state 0.
- sw with mem_ready low for 2 cycles in MEMWR -> memwrite=1 for 3 consecutive cycles, then FETCH. regwrite never 1.
- beq with zero=1, then with zero=0 -> pcen=1 in BEQEX with pcsrc=01, alucontrol=110 in the first case. pcen=0 in BEQEX in the second case.
- R-type with funct=101010, then funct=000000 -> first: alucontrol=111 in RTEX, regdst=1 and regwrite=1 in RTWB. Second: TRAP, illegal=1, no regwrite.
- op=111111 -> DECODE then TRAP. illegal holds until reset_n low, after which state=0 and illegal=0.
- reset_n pulsed low during MEMWR with mem_ready=0 -> memwrite drops to 0 asynchronously. Restart in FETCH with alusrcb=01.
